// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 device-to-host receiver; syncs and glitch-filters the pins,
// deserializes 11-bit frames, checks odd parity and stop, and presents good bytes.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   ps2_clk, ps2_data   raw asynchronous PS/2 pins
//   scancode[7:0]       last accepted byte, held until the next accepted byte
//   code_valid          one-cycle pulse when scancode updates
//   frame_err           one-cycle pulse on parity, stop or timeout error
//   busy                high while a frame is in progress
//   break_valid         (PS2_BREAK_FILTER_EN only) pulse for the byte following 0xF0
// Define PS2_BREAK_FILTER_EN to swallow break sequences so only make codes reach code_valid.
module ps2_scancode_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       code_valid,
    output logic       frame_err,
    output logic       busy
`ifdef PS2_BREAK_FILTER_EN
    ,
    output logic       break_valid
`endif
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, state_nxt;
    logic c_s1, c_s2, d_s1, d_s2;
    logic [FILTER_LEN-1:0] flt;
    logic fclk, fclk_d, fall;
    logic [7:0] sh;
    logic [2:0] cnt;
    logic par;
    logic [TW-1:0] tmo;
    logic timeout, accept, err;
`ifdef PS2_BREAK_FILTER_EN
    logic brk_pend;
    logic is_f0;
    assign is_f0 = (sh == 8'hF0);
`endif
    assign fall    = fclk_d & ~fclk;
    assign busy    = (state != IDLE);
    // a fall in the same cycle as expiry keeps the frame alive
    assign timeout = busy && !fall && (tmo == TW'(TIMEOUT_CYC - 1));
    always_ff @(posedge clk) begin
        if (reset) begin
            c_s1   <= 1'b1;
            c_s2   <= 1'b1;
            d_s1   <= 1'b1;
            d_s2   <= 1'b1;
            flt    <= '1;
            fclk   <= 1'b1;
            fclk_d <= 1'b1;
        end else begin
            c_s1   <= ps2_clk;
            c_s2   <= c_s1;
            d_s1   <= ps2_data;
            d_s2   <= d_s1;
            flt    <= {flt[FILTER_LEN-2:0], c_s2};
            // level only moves once the whole window agrees
            fclk   <= (&flt) ? 1'b1 : (~|flt) ? 1'b0 : fclk;
            fclk_d <= fclk;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        err       = 1'b0;
        if (fall) begin
            case (state)
                IDLE:    state_nxt = d_s2 ? IDLE : DATA;
                DATA:    state_nxt = (cnt == 3'd7) ? PARITY : DATA;
                PARITY:  state_nxt = STOP;
                STOP: begin
                    state_nxt = IDLE;
                    accept    = d_s2 & (^sh ^ par);
                    err       = ~accept;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (timeout) begin
            state_nxt = IDLE;
            err       = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sh         <= '0;
            cnt        <= '0;
            par        <= 1'b0;
            tmo        <= '0;
            scancode   <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            tmo       <= (!busy || fall || timeout) ? '0 : tmo + TW'(1);
            cnt       <= (state == IDLE) ? 3'd0 : (fall && state == DATA) ? cnt + 3'd1 : cnt;
            sh        <= (fall && state == DATA) ? {d_s2, sh[7:1]} : sh;
            par       <= (fall && state == PARITY) ? d_s2 : par;
            frame_err <= err;
`ifdef PS2_BREAK_FILTER_EN
            code_valid <= accept & ~brk_pend & ~is_f0;
            scancode   <= (accept & ~brk_pend & ~is_f0) ? sh : scancode;
`else
            code_valid <= accept;
            scancode   <= accept ? sh : scancode;
`endif
        end
    end
`ifdef PS2_BREAK_FILTER_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            brk_pend    <= 1'b0;
            break_valid <= 1'b0;
        end else begin
            break_valid <= accept & brk_pend;
            // the byte after 0xF0 consumes the flag, even if it is 0xF0 again
            brk_pend    <= err ? 1'b0 : accept ? (~brk_pend & is_f0) : brk_pend;
        end
    end
`endif
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: scoreboard bench for ps2_scancode_rx with randomized frames.
module tb_ps2_scancode_rx;
    localparam int FL = 8;
    localparam int T  = 400;
    localparam int HP = 20;
    localparam int K_CODE = 0, K_ERR = 1, K_BRK = 2;

    typedef struct {
        int         kind;
        logic [7:0] sc;
        bit         tmo;
    } exp_t;

    logic clk = 0, reset = 1, ps2_clk = 1, ps2_data = 1;
    logic [7:0] scancode;
    logic code_valid, frame_err, busy, break_valid;
    int checks = 0, errors = 0;
    int cyc = 0, fall_cyc = 0;
    exp_t exp_q[$];
    logic [7:0] sc_m = 8'h00;
    bit brk_m = 0;
    logic prev_any = 0;

    ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scancode(scancode), .code_valid(code_valid), .frame_err(frame_err), .busy(busy)
`ifdef PS2_BREAK_FILTER_EN
        , .break_valid(break_valid)
`endif
    );
`ifndef PS2_BREAK_FILTER_EN
    assign break_valid = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset && (code_valid | frame_err | break_valid)) begin
            check("one_output", $countones({code_valid, frame_err, break_valid}), 1);
            check("pulse_width", prev_any, 0);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cv=%0b fe=%0b bv=%0b sc=%0h", code_valid, frame_err, break_valid, scancode);
            end else begin
                exp_t e;
                int d;
                e = exp_q.pop_front();
                d = cyc - fall_cyc;
                check("kind", code_valid ? K_CODE : frame_err ? K_ERR : K_BRK, e.kind);
                check("scancode", scancode, e.sc);
                if (e.tmo) check("timeout_latency", (d >= T && d <= T + FL + 8), 1);
                else       check("stop_latency", (d >= FL + 2 && d <= FL + 6), 1);
            end
        end
        prev_any <= reset ? 1'b0 : (code_valid | frame_err | break_valid);
    end

    // reference model: rules of a frame, not of the receiver's state machine
    function automatic void model(input logic [7:0] b, input bit par, input bit stp);
        bit good;
        good = stp && ((^b ^ par) == 1'b1);
        if (!good) begin
            brk_m = 0;
            exp_q.push_back('{K_ERR, sc_m, 0});
        end else begin
`ifdef PS2_BREAK_FILTER_EN
            if (brk_m) begin
                brk_m = 0;
                exp_q.push_back('{K_BRK, sc_m, 0});
            end else if (b == 8'hF0) brk_m = 1;
            else begin
                sc_m = b;
                exp_q.push_back('{K_CODE, sc_m, 0});
            end
`else
            sc_m = b;
            exp_q.push_back('{K_CODE, sc_m, 0});
`endif
        end
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (HP) @(negedge clk);
            if (glitch) begin
                ps2_clk = 0;
                repeat (FL - 1) @(negedge clk);
                ps2_clk = 1;
                repeat (HP) @(negedge clk);
            end
            ps2_clk = 0;
            fall_cyc = cyc;
            repeat (HP) @(negedge clk);
            ps2_clk = 1;
        end
        ps2_data = 1;
    endtask

    task automatic frame(input logic [7:0] b, input bit par, input bit stp, input bit glitch);
        model(b, par, stp);
        send_bits({stp, par, b, 1'b0}, 11, glitch);
    endtask

    task automatic good(input logic [7:0] b);
        frame(b, ~^b, 1'b1, 1'b0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < T + 200 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_scancode", scancode, 8'h00);
        check("rst_code_valid", code_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);
        check("rst_break_valid", break_valid, 0);
    endtask

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (10) @(negedge clk);
        check_reset_outputs();
        reset = 0;
        repeat (20) @(negedge clk);

        frame(8'h03, 1'b1, 1'b1, 1'b0);
        drain("drain_03");
        check("busy_after_03", busy, 0);
        check("sc_03", scancode, 8'h03);

        frame(8'h0B, 1'b0, 1'b1, 1'b0);
        frame(8'h83, 1'b0, 1'b1, 1'b0);
        drain("drain_b2b");
        check("sc_83", scancode, 8'h83);

        frame(8'h0B, 1'b1, 1'b1, 1'b0);
        frame(8'h0B, 1'b0, 1'b0, 1'b0);
        drain("drain_bad");
        check("sc_keep_83", scancode, 8'h83);

        brk_m = 0;
        exp_q.push_back('{K_ERR, sc_m, 1});
        send_bits({2'b11, 8'h05, 1'b0}, 5, 1'b0);
        repeat (T - 20 - HP) @(negedge clk);
        check("busy_before_timeout", busy, 1);
        drain("drain_timeout");
        check("busy_after_timeout", busy, 0);
        good(8'h03);
        drain("drain_after_timeout");

        for (int i = 0; i < 3; i++) begin
            ps2_clk = 0;
            repeat (FL - 1) @(negedge clk);
            ps2_clk = 1;
            repeat (HP) @(negedge clk);
        end
        check("idle_glitch_busy", busy, 0);
        frame(8'h5A, ~^8'h5A, 1'b1, 1'b1);
        frame(8'hE0, ~^8'hE0, 1'b1, 1'b1);
        drain("drain_glitch");
        check("sc_glitch", scancode, 8'hE0);

        send_bits({2'b11, 8'h3C, 1'b0}, 6, 1'b0);
        check("busy_midframe", busy, 1);
        reset = 1;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 0;
        sc_m = 8'h00;
        brk_m = 0;
        repeat (T + 50) @(negedge clk);
        check("busy_after_reset", busy, 0);
        good(8'h0B);
        good(8'hF0);
        good(8'h0B);
        drain("drain_break");
        check("sc_break_seq", scancode, sc_m);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            int m;
            b = 8'($urandom);
            if (i % 7 == 3) b = 8'hF0;
            m = $urandom_range(0, 4);
            frame(b, (m == 0) ? ^b : ~^b, m != 1, 1'b0);
        end
        drain("drain_random");
        check("sc_random", scancode, sc_m);
        check("busy_end", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
